apb2ahb: RTL and testbench

APB2AHB -- requirements
Module: apb2ahb

---
 rtl/ahb_names_pkg.sv | 22 ++
 rtl/apb_names_pkg.sv | 18 +
 rtl/apb2ahb_strb_dec.sv | 57 +++++
 rtl/apb2ahb.sv | 148 ++++++++++++++
 tb/tb_apb2ahb.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_names_pkg.sv
// AHB-Lite encodings shared by the APB-to-AHB bridge.
package ahb_names_pkg;

   // HTRANS transfer types
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   // HSIZE transfer sizes used on a 32-bit bus
   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } hsize_t;

   // HBURST: the bridge only ever issues single transfers
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/apb_names_pkg.sv
// APB-side bridge state and protection mapping.
package apb_names_pkg;

   // Bridge sequencing: APB setup -> AHB address -> AHB data -> APB completion
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   // APB PPROT -> AHB HPROT: privileged follows pprot[0], data/opcode is the
   // inverse of the APB instruction bit; non-bufferable, non-cacheable.
   function automatic logic [3:0] prot_map(input logic i_priv, input logic i_instr);
      return {1'b0, 1'b0, i_priv, ~i_instr};
   endfunction

endpackage

// File: rtl/apb2ahb_strb_dec.sv
// Decodes an APB write strobe pattern into an aligned AHB size and low address.
module apb2ahb_strb_dec
   import ahb_names_pkg::*;
(
   input  logic         i_write,
   input  logic [3:0]   i_strb,
   output hsize_t       o_hsize,
   output logic [1:0]   o_alo,
   output logic         o_legal
);

   // Only naturally aligned byte, halfword and word patterns are legal writes;
   // reads always fetch the whole aligned word.
   always_comb begin
      o_hsize = HSIZE_WORD;
      o_alo   = 2'b00;
      o_legal = 1'b1;
      if (i_write) begin
         case (i_strb)
            4'b1111: begin
               o_hsize = HSIZE_WORD;
               o_alo   = 2'b00;
            end
            4'b0011: begin
               o_hsize = HSIZE_HALF;
               o_alo   = 2'b00;
            end
            4'b1100: begin
               o_hsize = HSIZE_HALF;
               o_alo   = 2'b10;
            end
            4'b0001: begin
               o_hsize = HSIZE_BYTE;
               o_alo   = 2'b00;
            end
            4'b0010: begin
               o_hsize = HSIZE_BYTE;
               o_alo   = 2'b01;
            end
            4'b0100: begin
               o_hsize = HSIZE_BYTE;
               o_alo   = 2'b10;
            end
            4'b1000: begin
               o_hsize = HSIZE_BYTE;
               o_alo   = 2'b11;
            end
            default: begin
               o_hsize = HSIZE_WORD;
               o_alo   = 2'b00;
               o_legal = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/apb2ahb.sv
// APB completer to AHB-Lite manager bridge: one APB access becomes one AHB
// SINGLE transfer, with all bus outputs registered.
module apb2ahb
   import ahb_names_pkg::*;
   import apb_names_pkg::*;
#(
   parameter int unsigned ADDR  = 32,
   parameter int unsigned HDATA = 32,
   parameter int unsigned PDATA = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   // APB completer
   input  logic                 psel,
   input  logic                 penable,
   input  logic [ADDR-1:0]      paddr,
   input  logic                 pwrite,
   input  logic [PDATA/8-1:0]   pstrb,
   input  logic [PDATA-1:0]     pwdata,
   input  logic [2:0]           pprot,
   output logic [PDATA-1:0]     prdata,
   output logic                 pready,
   output logic                 pslverr,
   // AHB-Lite manager
   output logic [1:0]           htrans,
   output logic [2:0]           hburst,
   output logic [2:0]           hsize,
   output logic [3:0]           hprot,
   output logic                 hmastlock,
   output logic [ADDR-1:0]      haddr,
   output logic                 hwrite,
   output logic [HDATA-1:0]     hwdata,
   input  logic [HDATA-1:0]     hrdata,
   input  logic                 hready,
   input  logic                 hresp
);

   state_t              r_state;
   htrans_t             r_htrans;
   hsize_t              r_hsize;
   logic [ADDR-1:0]     r_haddr;
   logic                r_hwrite;
   logic [3:0]          r_hprot;
   logic [HDATA-1:0]    r_hwdata;
   logic [PDATA-1:0]    r_wdata;
   logic [PDATA-1:0]    r_prdata;
   logic                r_pready;
   logic                r_pslverr;

   hsize_t              w_hsize;
   logic [1:0]          w_alo;
   logic                w_legal;
   logic                w_setup;
   logic                w_unused;

   // APB setup phase: selected but not yet in the access phase
   assign w_setup = psel & ~penable;

   // The low address bits come from the strobes, and pprot[1] has no AHB
   // counterpart, so those input bits are intentionally dropped.
   assign w_unused = &{1'b0, paddr[1:0], pprot[1]};

   apb2ahb_strb_dec u_strb_dec (
      .i_write (pwrite),
      .i_strb  (pstrb),
      .o_hsize (w_hsize),
      .o_alo   (w_alo),
      .o_legal (w_legal)
   );

   // Bridge sequencer; every bus output is a register updated here.
   // The decoded strobes (size + low address) are what is kept of pstrb.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_htrans  <= HTRANS_IDLE;
         r_hsize   <= HSIZE_BYTE;
         r_haddr   <= '0;
         r_hwrite  <= 1'b0;
         r_hprot   <= '0;
         r_hwdata  <= '0;
         r_wdata   <= '0;
         r_prdata  <= '0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_setup) begin
                  if (w_legal) begin
                     r_wdata  <= pwdata;
                     r_hwrite <= pwrite;
                     r_hsize  <= w_hsize;
                     r_haddr  <= {paddr[ADDR-1:2], w_alo};
                     r_hprot  <= prot_map(pprot[0], pprot[2]);
                     r_htrans <= HTRANS_NONSEQ;
                     r_state  <= ST_ADDR;
                  end else begin
                     // Illegal strobes complete on APB without touching AHB
                     r_prdata  <= '0;
                     r_pready  <= 1'b1;
                     r_pslverr <= 1'b1;
                     r_state   <= ST_DONE;
                  end
               end
            end
            ST_ADDR: begin
               if (hready) begin
                  r_htrans <= HTRANS_IDLE;
                  r_hwdata <= r_wdata;
                  r_state  <= ST_DATA;
               end
            end
            ST_DATA: begin
               // An error's first (hready=0) cycle is simply waited through
               if (hready) begin
                  r_prdata  <= (r_hwrite || hresp) ? '0 : hrdata;
                  r_pslverr <= hresp;
                  r_pready  <= 1'b1;
                  r_state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_prdata  <= '0;
               r_pready  <= 1'b0;
               r_pslverr <= 1'b0;
               r_state   <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign htrans    = r_htrans;
   assign hburst    = HBURST_SINGLE;
   assign hsize     = r_hsize;
   assign hprot     = r_hprot;
   assign hmastlock = 1'b0;
   assign haddr     = r_haddr;
   assign hwrite    = r_hwrite;
   assign hwdata    = r_hwdata;
   assign prdata    = r_prdata;
   assign pready    = r_pready;
   assign pslverr   = r_pslverr;

endmodule

// File: tb/tb_apb2ahb.sv
// Self-checking bench for apb2ahb: APB master + AHB slave driven from tables,
// expectations queued at drive time and retired when pready appears.
module tb_apb2ahb;

   logic          clk = 1'b0;
   logic          reset;
   logic          psel;
   logic          penable;
   logic [31:0]   paddr;
   logic          pwrite;
   logic [3:0]    pstrb;
   logic [31:0]   pwdata;
   logic [2:0]    pprot;
   logic [31:0]   prdata;
   logic          pready;
   logic          pslverr;
   logic [1:0]    htrans;
   logic [2:0]    hburst;
   logic [2:0]    hsize;
   logic [3:0]    hprot;
   logic          hmastlock;
   logic [31:0]   haddr;
   logic          hwrite;
   logic [31:0]   hwdata;
   logic [31:0]   hrdata;
   logic          hready;
   logic          hresp;

   always #5 clk = ~clk;

   apb2ahb #(.ADDR(32), .HDATA(32), .PDATA(32)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .psel      (psel),
      .penable   (penable),
      .paddr     (paddr),
      .pwrite    (pwrite),
      .pstrb     (pstrb),
      .pwdata    (pwdata),
      .pprot     (pprot),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr),
      .htrans    (htrans),
      .hburst    (hburst),
      .hsize     (hsize),
      .hprot     (hprot),
      .hmastlock (hmastlock),
      .haddr     (haddr),
      .hwrite    (hwrite),
      .hwdata    (hwdata),
      .hrdata    (hrdata),
      .hready    (hready),
      .hresp     (hresp)
   );

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      string         name;
      logic          wr;
      logic [31:0]   addr;
      logic [31:0]   wdata;
      logic [3:0]    strb;
      logic [2:0]    prot;
      logic          legal;
      logic [31:0]   ex_haddr;
      logic [2:0]    ex_hsize;
      logic [3:0]    ex_hprot;
      int            aw;
      int            dw;
      logic          err;
      logic [31:0]   rdata;
      logic          drop;
   } row_t;

   typedef struct {
      string         name;
      logic [31:0]   prdata;
      logic          slverr;
      int            lat;
      int            ns;
      logic [31:0]   haddr;
      logic [2:0]    hsize;
      logic          hwrite;
      logic [3:0]    hprot;
      logic [31:0]   hwdata;
   } exp_t;

   exp_t sb[$];

   function automatic row_t mk(input string name, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                               input logic legal, input logic [31:0] ex_haddr, input logic [2:0] ex_hsize,
                               input logic [3:0] ex_hprot, input int aw, input int dw, input logic err,
                               input logic [31:0] rdata, input logic drop);
      row_t r;
      r.name = name; r.wr = wr; r.addr = addr; r.wdata = wdata; r.strb = strb; r.prot = prot;
      r.legal = legal; r.ex_haddr = ex_haddr; r.ex_hsize = ex_hsize; r.ex_hprot = ex_hprot;
      r.aw = aw; r.dw = dw; r.err = err; r.rdata = rdata; r.drop = drop;
      return r;
   endfunction

   // One APB transfer with a cooperating AHB slave; starts one cycle after a posedge.
   task automatic apb_xfer(input row_t r);
      exp_t e;
      exp_t g;
      int   k;
      int   ns;
      int   dcnt;
      logic dph;
      logic seen;
      e.name   = r.name;
      e.prdata = (!r.legal || r.wr || r.err) ? 32'h0 : r.rdata;
      e.slverr = !r.legal || r.err;
      e.lat    = r.legal ? (3 + r.aw + r.dw) : 1;
      e.ns     = r.legal ? (1 + r.aw) : 0;
      e.haddr  = r.ex_haddr;
      e.hsize  = r.ex_hsize;
      e.hwrite = r.wr;
      e.hprot  = r.ex_hprot;
      e.hwdata = r.wdata;
      psel = 1'b1; penable = 1'b0; paddr = r.addr; pwrite = r.wr; pwdata = r.wdata;
      pstrb = r.strb; pprot = r.prot; hready = 1'b1; hresp = 1'b0; hrdata = 32'hBAD0_BAD0;
      sb.push_back(e);
      @(posedge clk); #1;
      if (r.drop) begin
         psel = 1'b0; penable = 1'b0;
      end else begin
         penable = 1'b1;
      end
      k = 0; ns = 0; dcnt = 0; dph = 1'b0; seen = 1'b0;
      while (!seen && k < 40) begin
         if (pready) begin
            seen = 1'b1;
         end else begin
            if (htrans == 2'b10) begin
               ns++;
               chk_eq({r.name, ".haddr"},  haddr,  sb[0].haddr);
               chk_eq({r.name, ".hsize"},  {29'd0, hsize}, {29'd0, sb[0].hsize});
               chk_eq({r.name, ".hwrite"}, {31'd0, hwrite}, {31'd0, sb[0].hwrite});
               chk_eq({r.name, ".hprot"},  {28'd0, hprot}, {28'd0, sb[0].hprot});
               if (ns <= r.aw) begin
                  hready = 1'b0;
               end else begin
                  hready = 1'b1; hresp = 1'b0; dph = 1'b1;
               end
            end else if (dph) begin
               if (r.wr) chk_eq({r.name, ".hwdata"}, hwdata, sb[0].hwdata);
               hresp = r.err;
               if (dcnt < r.dw) begin
                  hready = 1'b0; dcnt++;
               end else begin
                  hready = 1'b1; hrdata = r.rdata; dph = 1'b0;
               end
            end else begin
               hready = 1'b1; hresp = 1'b0;
            end
            @(posedge clk); #1;
            k++;
         end
      end
      chk_eq({r.name, ".seen"}, {31'd0, seen}, 32'd1);
      if (seen) begin
         g = sb.pop_front();
         chk_eq({g.name, ".lat"},     k + 1, g.lat);
         chk_eq({g.name, ".prdata"},  prdata, g.prdata);
         chk_eq({g.name, ".pslverr"}, {31'd0, pslverr}, {31'd0, g.slverr});
         chk_eq({g.name, ".nonseq"},  ns, g.ns);
         @(posedge clk); #1;
         psel = 1'b0; penable = 1'b0;
         chk_eq({g.name, ".pready1"}, {31'd0, pready}, 32'd0);
      end else begin
         sb.delete();
         psel = 1'b0; penable = 1'b0;
      end
      hready = 1'b1; hresp = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic reset_values(input string tag);
      chk_eq({tag, ".htrans"},  {30'd0, htrans}, 32'd0);
      chk_eq({tag, ".haddr"},   haddr, 32'd0);
      chk_eq({tag, ".hwrite"},  {31'd0, hwrite}, 32'd0);
      chk_eq({tag, ".hsize"},   {29'd0, hsize}, 32'd0);
      chk_eq({tag, ".hprot"},   {28'd0, hprot}, 32'd0);
      chk_eq({tag, ".hwdata"},  hwdata, 32'd0);
      chk_eq({tag, ".prdata"},  prdata, 32'd0);
      chk_eq({tag, ".pready"},  {31'd0, pready}, 32'd0);
      chk_eq({tag, ".pslverr"}, {31'd0, pslverr}, 32'd0);
   endtask

   // Reset asserted between edges while the bridge sits in its data phase.
   task automatic reset_mid();
      int npr;
      psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0ABC; pwrite = 1'b1; pwdata = 32'hA5A5_5A5A;
      pstrb = 4'hF; pprot = 3'b001; hready = 1'b1; hresp = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      hready = 1'b0;
      chk_eq("rst.pre_hwdata", hwdata, 32'hA5A5_5A5A);
      chk_eq("rst.pre_haddr",  haddr,  32'h0000_0ABC);
      #2 reset = 1'b1;
      #1 reset_values("rst_mid");
      psel = 1'b0; penable = 1'b0; hready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      npr = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (pready || htrans != 2'b00) npr++;
      end
      chk_eq("rst.no_activity", npr, 0);
   endtask

   row_t rows[16];

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pstrb = '0;
      pwdata = '0; pprot = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
      #2 reset = 1'b1;
      #2 reset_values("por");
      chk_eq("por.hburst",    {29'd0, hburst}, 32'd0);
      chk_eq("por.hmastlock", {31'd0, hmastlock}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      //            name        wr    addr          wdata          strb     prot    legal haddr         hsz   hprot    aw dw err   rdata          drop
      rows[0]  = mk("wr_word",  1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 3'b000, 1'b1, 32'h0000_0100, 3'd2, 4'b0001, 0, 0, 1'b0, 32'h0,         1'b0);
      rows[1]  = mk("rd_wait2", 1'b0, 32'h0000_0204, 32'h0,         4'b0000, 3'b000, 1'b1, 32'h0000_0204, 3'd2, 4'b0001, 0, 2, 1'b0, 32'h1234_5678, 1'b0);
      rows[2]  = mk("wr_byte2", 1'b1, 32'h0000_0010, 32'h00AB_0000, 4'b0100, 3'b000, 1'b1, 32'h0000_0012, 3'd0, 4'b0001, 0, 0, 1'b0, 32'h0,         1'b0);
      rows[3]  = mk("wr_bad5",  1'b1, 32'h0000_0010, 32'h1111_2222, 4'b0101, 3'b000, 1'b0, 32'h0,         3'd0, 4'b0000, 0, 0, 1'b0, 32'h0,         1'b0);
      rows[4]  = mk("wr_bad0",  1'b1, 32'h0000_0020, 32'h3333_4444, 4'b0000, 3'b000, 1'b0, 32'h0,         3'd0, 4'b0000, 0, 0, 1'b0, 32'h0,         1'b0);
      rows[5]  = mk("rd_err",   1'b0, 32'h0000_0300, 32'h0,         4'b0000, 3'b000, 1'b1, 32'h0000_0300, 3'd2, 4'b0001, 0, 1, 1'b1, 32'hCAFE_F00D, 1'b0);
      rows[6]  = mk("wr_hw_hi", 1'b1, 32'h0000_0020, 32'hBEEF_0000, 4'b1100, 3'b000, 1'b1, 32'h0000_0022, 3'd1, 4'b0001, 0, 0, 1'b0, 32'h0,         1'b0);
      rows[7]  = mk("wr_hw_lo", 1'b1, 32'h0000_0033, 32'h0000_5A5A, 4'b0011, 3'b000, 1'b1, 32'h0000_0030, 3'd1, 4'b0001, 0, 0, 1'b0, 32'h0,         1'b0);
      rows[8]  = mk("wr_byte3", 1'b1, 32'h0000_0041, 32'h7700_0000, 4'b1000, 3'b000, 1'b1, 32'h0000_0043, 3'd0, 4'b0001, 0, 0, 1'b0, 32'h0,         1'b0);
      rows[9]  = mk("rd_unal",  1'b0, 32'h0000_0207, 32'h0,         4'b0000, 3'b101, 1'b1, 32'h0000_0204, 3'd2, 4'b0010, 0, 0, 1'b0, 32'hA1B2_C3D4, 1'b0);
      rows[10] = mk("wr_aw1",   1'b1, 32'h0000_0400, 32'h1357_9BDF, 4'b1111, 3'b010, 1'b1, 32'h0000_0400, 3'd2, 4'b0001, 1, 0, 1'b0, 32'h0,         1'b0);
      rows[11] = mk("rd_drop",  1'b0, 32'h0000_0500, 32'h0,         4'b0000, 3'b011, 1'b1, 32'h0000_0500, 3'd2, 4'b0011, 0, 0, 1'b0, 32'h89AB_CDEF, 1'b1);
      rows[12] = mk("wr_byte0", 1'b1, 32'h0000_0060, 32'h0000_00C3, 4'b0001, 3'b000, 1'b1, 32'h0000_0060, 3'd0, 4'b0001, 0, 0, 1'b0, 32'h0,         1'b0);
      rows[13] = mk("wr_byte1", 1'b1, 32'h0000_0060, 32'h0000_3C00, 4'b0010, 3'b100, 1'b1, 32'h0000_0061, 3'd0, 4'b0000, 0, 1, 1'b0, 32'h0,         1'b0);
      rows[14] = mk("wr_err",   1'b1, 32'h0000_0700, 32'h0F0F_0F0F, 4'b1111, 3'b000, 1'b1, 32'h0000_0700, 3'd2, 4'b0001, 0, 1, 1'b1, 32'hFFFF_FFFF, 1'b0);
      rows[15] = mk("wr_bad6",  1'b1, 32'h0000_0080, 32'h5555_6666, 4'b0110, 3'b000, 1'b0, 32'h0,         3'd0, 4'b0000, 0, 0, 1'b0, 32'h0,         1'b0);

      foreach (rows[i]) apb_xfer(rows[i]);

      reset_mid();
      apb_xfer(mk("post_rst", 1'b0, 32'h0000_0ABC, 32'h0, 4'b0000, 3'b001, 1'b1, 32'h0000_0ABC, 3'd2, 4'b0011, 0, 0, 1'b0, 32'h600D_D00D, 1'b0));

      chk_eq("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
